decode_skid_reg: RTL and testbench

// Parametrised decode->execute pipeline register with a valid/ready handshake and a 2-entry skid buffer.

---
 rtl/decode_skid_reg.sv | 115 +++++++++++
 tb/tb_decode_skid_reg.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_skid_reg.sv
// Decode->execute pipeline register with valid/ready handshake, 2-entry skid buffer,
// flush with NOP bubble insertion and saturating stall/flush event counters.
module decode_skid_reg #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 15,
    parameter logic [DWIDTH-1:0] NOP_INST = '0,
    parameter int CWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [AWIDTH-1:0] in_addr,
    input  logic [DWIDTH-1:0] in_immed,
    input  logic [DWIDTH-1:0] in_inst,
    input  logic [DWIDTH-1:0] in_rd1,
    input  logic [DWIDTH-1:0] in_rd2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AWIDTH-1:0] out_addr,
    output logic [DWIDTH-1:0] out_immed,
    output logic [DWIDTH-1:0] out_inst,
    output logic [DWIDTH-1:0] out_rd1,
    output logic [DWIDTH-1:0] out_rd2,
    output logic [CWIDTH-1:0] stall_cnt,
    output logic [CWIDTH-1:0] flush_cnt
);

    localparam int PW = AWIDTH + 4 * DWIDTH;
    localparam logic [PW-1:0] NOP_BEAT = {{AWIDTH{1'b0}}, {DWIDTH{1'b0}}, NOP_INST,
                                          {DWIDTH{1'b0}}, {DWIDTH{1'b0}}};
    localparam logic [CWIDTH-1:0] CMAX = {CWIDTH{1'b1}};

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state;
    logic [PW-1:0]   main_q;
    logic [PW-1:0]   skid_q;
    logic [PW-1:0]   in_beat;
    logic            accept;
    logic            consume;

    assign in_beat = {in_addr, in_immed, in_inst, in_rd1, in_rd2};
    assign accept  = in_valid & in_ready;
    assign consume = out_valid & out_ready;

    assign {out_addr, out_immed, out_inst, out_rd1, out_rd2} = main_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= EMPTY;
            main_q    <= NOP_BEAT;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cnt != CMAX)
                stall_cnt <= stall_cnt + CWIDTH'(1);

            if (flush) begin
                // Beats accepted in the flush cycle are dropped along with held ones.
                if (state != EMPTY && flush_cnt != CMAX)
                    flush_cnt <= flush_cnt + CWIDTH'(1);
                state     <= EMPTY;
                main_q    <= NOP_BEAT;
                skid_q    <= '0;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
            end else begin
                case (state)
                    EMPTY: begin
                        if (accept) begin
                            main_q    <= in_beat;
                            out_valid <= 1'b1;
                            state     <= ONE;
                        end
                    end
                    ONE: begin
                        if (accept && consume) begin
                            main_q <= in_beat;
                        end else if (accept) begin
                            skid_q   <= in_beat;
                            in_ready <= 1'b0;
                            state    <= FULL;
                        end else if (consume) begin
                            main_q    <= NOP_BEAT;
                            out_valid <= 1'b0;
                            state     <= EMPTY;
                        end
                    end
                    FULL: begin
                        // in_ready is low here, so only a drain from skid can happen.
                        if (consume) begin
                            main_q   <= skid_q;
                            skid_q   <= '0;
                            in_ready <= 1'b1;
                            state    <= ONE;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        main_q    <= NOP_BEAT;
                        skid_q    <= '0;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_decode_skid_reg.sv
// Directed bench for decode_skid_reg: streaming, backpressure, flush, counter
// saturation and asynchronous reset while the buffer is full.
module tb_decode_skid_reg;

    localparam int DW = 32;
    localparam int AW = 15;
    localparam int CW = 4;
    localparam logic [DW-1:0] NOP = 32'h0000_0013;
    localparam int PW = AW + 4 * DW;
    localparam logic [PW-1:0] NOP_BEAT = {{AW{1'b0}}, {DW{1'b0}}, NOP, {DW{1'b0}}, {DW{1'b0}}};

    logic          clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [AW-1:0] in_addr, out_addr;
    logic [DW-1:0] in_immed, in_inst, in_rd1, in_rd2;
    logic [DW-1:0] out_immed, out_inst, out_rd1, out_rd2;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [PW-1:0] got;

    int errors = 0;
    int checks = 0;

    decode_skid_reg #(.DWIDTH(DW), .AWIDTH(AW), .NOP_INST(NOP), .CWIDTH(CW)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_immed(in_immed), .in_inst(in_inst),
        .in_rd1(in_rd1), .in_rd2(in_rd2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_immed(out_immed), .out_inst(out_inst),
        .out_rd1(out_rd1), .out_rd2(out_rd2),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    assign got = {out_addr, out_immed, out_inst, out_rd1, out_rd2};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [PW-1:0] beat(input int id);
        return {AW'(32'h100 + id), 32'hA000_0000 + id, 32'h1000_0000 + id,
                32'hB000_0000 + id, 32'hC000_0000 + id};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int id);
        logic [PW-1:0] b;
        b = beat(id);
        in_valid = 1'b1;
        {in_addr, in_immed, in_inst, in_rd1, in_rd2} = b;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        {in_addr, in_immed, in_inst, in_rd1, in_rd2} = '0;
    endtask

    task automatic do_reset();
        idle();
        flush = 1'b0;
        out_ready = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (got !== NOP_BEAT) begin errors++; $display("FAIL reset_payload: got %h want %h", got, NOP_BEAT); end
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0) begin errors++;
            $display("FAIL reset_counters: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    endtask

    task automatic test_streaming();
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(i);
            step();
            checks++; if (out_valid !== 1'b1 || got !== beat(i)) begin errors++;
                $display("FAIL stream_beat%0d: got v=%b %h want v=1 %h", i, out_valid, got, beat(i)); end
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_ready%0d: got %b want 1", i, in_ready); end
        end
        idle();
        step();
        checks++; if (out_valid !== 1'b0 || out_inst !== NOP) begin errors++;
            $display("FAIL stream_drain: got v=%b inst=%h want v=0 inst=%h", out_valid, out_inst, NOP); end
        checks++; if (stall_cnt !== 4'd0) begin errors++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        do_reset();
        out_ready = 1'b0;
        drive(10); step();
        checks++; if (got !== beat(10) || in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_a_loaded: got %h rdy=%b want %h rdy=1", got, in_ready, beat(10)); end
        drive(11); step();
        checks++; if (got !== beat(10) || in_ready !== 1'b0) begin errors++;
            $display("FAIL bp_b_skid: got %h rdy=%b want %h rdy=0", got, in_ready, beat(10)); end
        drive(12); step();
        checks++; if (got !== beat(10) || in_ready !== 1'b0 || out_valid !== 1'b1) begin errors++;
            $display("FAIL bp_hold: got v=%b %h rdy=%b want v=1 %h rdy=0", out_valid, got, in_ready, beat(10)); end
        out_ready = 1'b1;
        step();
        checks++; if (got !== beat(11) || in_ready !== 1'b1) begin errors++;
            $display("FAIL bp_release_b: got %h rdy=%b want %h rdy=1", got, in_ready, beat(11)); end
        step();
        checks++; if (got !== beat(12) || out_valid !== 1'b1) begin errors++;
            $display("FAIL bp_release_c: got v=%b %h want v=1 %h", out_valid, got, beat(12)); end
        idle(); step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b want 0", out_valid); end
        checks++; if (stall_cnt !== 4'd2) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 2", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        drive(20); step();
        drive(21); step();
        idle();
        flush = 1'b1;
        step();
        flush = 1'b0;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL flush_full_hs: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        checks++; if (got !== NOP_BEAT) begin errors++; $display("FAIL flush_full_payload: got %h want %h", got, NOP_BEAT); end
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL flush_full_cnt: got %0d want 1", flush_cnt); end
        // From EMPTY: accept and flush together, beat must vanish and count must not move.
        out_ready = 1'b1;
        drive(22);
        flush = 1'b1;
        step();
        flush = 1'b0;
        idle();
        checks++; if (out_valid !== 1'b0 || out_inst !== NOP) begin errors++;
            $display("FAIL flush_accept_out: got v=%b inst=%h want v=0 inst=%h", out_valid, out_inst, NOP); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_accept_after: got %b want 0", out_valid); end
        checks++; if (flush_cnt !== 4'd1) begin errors++; $display("FAIL flush_accept_cnt: got %0d want 1", flush_cnt); end
    endtask

    task automatic test_saturation();
        do_reset();
        drive(30); step();
        idle();
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                checks++; if (stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d want 14", stall_cnt); end
            end
            if (i == 15) begin
                checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_15: got %0d want 15", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold: got %0d want 15", stall_cnt); end
        checks++; if (got !== beat(30) || out_valid !== 1'b1) begin errors++;
            $display("FAIL sat_payload: got v=%b %h want v=1 %h", out_valid, got, beat(30)); end
    endtask

    task automatic test_async_reset();
        do_reset();
        drive(40); step();
        drive(41); step();
        flush = 1'b0;
        idle();
        checks++; if (in_ready !== 1'b0 || stall_cnt === 4'd0) begin errors++;
            $display("FAIL areset_pre: got rdy=%b stall=%0d want rdy=0 stall>0", in_ready, stall_cnt); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL areset_hs: got v=%b rdy=%b want v=0 rdy=1", out_valid, in_ready); end
        checks++; if (stall_cnt !== 4'd0 || flush_cnt !== 4'd0 || got !== NOP_BEAT) begin errors++;
            $display("FAIL areset_state: got %0d/%0d %h want 0/0 %h", stall_cnt, flush_cnt, got, NOP_BEAT); end
        step();
        rst = 1'b0;
        out_ready = 1'b1;
        drive(42); step();
        idle();
        checks++; if (got !== beat(42) || out_valid !== 1'b1) begin errors++;
            $display("FAIL areset_resume: got v=%b %h want v=1 %h", out_valid, got, beat(42)); end
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_no_stale_skid: got %b want 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        out_ready = 1'b0;
        idle();
        test_reset();
        test_streaming();
        test_backpressure();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
